// File: rtl/reg_bank_initiator.sv
// reg_bank_initiator: accepts write / read-pair commands and drives an
// external register bank. Writes pulse Escrita for one cycle; reads present
// two source indices for one cycle, capture the bank's combinational read
// data and hold it on a valid/ready response port until it is taken.
module reg_bank_initiator #(
  parameter int WIDTH = 32,
  parameter int AW    = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic             CmdOp,
  input  logic [AW-1:0]    CmdReg,
  input  logic [AW-1:0]    CmdSrc1,
  input  logic [AW-1:0]    CmdSrc2,
  input  logic [WIDTH-1:0] CmdDado,
  output logic             RespValid,
  input  logic             RespReady,
  output logic [WIDTH-1:0] RespDado1,
  output logic [WIDTH-1:0] RespDado2,
  output logic [AW-1:0]    IdReg,
  output logic [AW-1:0]    Fonte1,
  output logic [AW-1:0]    Fonte2,
  output logic             Escrita,
  output logic [WIDTH-1:0] Dado,
  input  logic [WIDTH-1:0] DadoLido1,
  input  logic [WIDTH-1:0] DadoLido2,
  output logic [7:0]       WrCount,
  output logic [7:0]       RdCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             escrita_q, escrita_d;
  logic             resp_valid_q, resp_valid_d;
  logic [AW-1:0]    id_reg_q, id_reg_d;
  logic [AW-1:0]    fonte1_q, fonte1_d;
  logic [AW-1:0]    fonte2_q, fonte2_d;
  logic [WIDTH-1:0] dado_q, dado_d;
  logic [WIDTH-1:0] resp_dado1_q, resp_dado1_d;
  logic [WIDTH-1:0] resp_dado2_q, resp_dado2_d;
  logic [7:0]       wr_count_q, wr_count_d;
  logic [7:0]       rd_count_q, rd_count_d;

  // Next-state and next-output computation; every output is taken from a flop.
  always_comb begin
    state_d      = state_q;
    escrita_d    = escrita_q;
    resp_valid_d = resp_valid_q;
    id_reg_d     = id_reg_q;
    fonte1_d     = fonte1_q;
    fonte2_d     = fonte2_q;
    dado_d       = dado_q;
    resp_dado1_d = resp_dado1_q;
    resp_dado2_d = resp_dado2_q;
    wr_count_d   = wr_count_q;
    rd_count_d   = rd_count_q;
    unique case (state_q)
      IDLE: begin
        if (CmdValid) begin
          if (!CmdOp) begin
            id_reg_d  = CmdReg;
            dado_d    = CmdDado;
            escrita_d = 1'b1;
            state_d   = WRITE;
          end else begin
            fonte1_d = CmdSrc1;
            fonte2_d = CmdSrc2;
            state_d  = READ;
          end
        end
      end
      WRITE: begin
        // The bank samples on this cycle's falling edge; IdReg/Dado stay put.
        escrita_d  = 1'b0;
        wr_count_d = wr_count_q + 8'd1;
        state_d    = IDLE;
      end
      READ: begin
        resp_dado1_d = DadoLido1;
        resp_dado2_d = DadoLido2;
        resp_valid_d = 1'b1;
        rd_count_d   = rd_count_q + 8'd1;
        state_d      = RESP;
      end
      RESP: begin
        if (RespReady) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      escrita_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      id_reg_q     <= '0;
      fonte1_q     <= '0;
      fonte2_q     <= '0;
      dado_q       <= '0;
      resp_dado1_q <= '0;
      resp_dado2_q <= '0;
      wr_count_q   <= '0;
      rd_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      escrita_q    <= escrita_d;
      resp_valid_q <= resp_valid_d;
      id_reg_q     <= id_reg_d;
      fonte1_q     <= fonte1_d;
      fonte2_q     <= fonte2_d;
      dado_q       <= dado_d;
      resp_dado1_q <= resp_dado1_d;
      resp_dado2_q <= resp_dado2_d;
      wr_count_q   <= wr_count_d;
      rd_count_q   <= rd_count_d;
    end
  end

  assign CmdReady  = (state_q == IDLE);
  assign RespValid = resp_valid_q;
  assign RespDado1 = resp_dado1_q;
  assign RespDado2 = resp_dado2_q;
  assign IdReg     = id_reg_q;
  assign Fonte1    = fonte1_q;
  assign Fonte2    = fonte2_q;
  assign Escrita   = escrita_q;
  assign Dado      = dado_q;
  assign WrCount   = wr_count_q;
  assign RdCount   = rd_count_q;

endmodule

// File: tb/tb_reg_bank_initiator.sv
// Bench for reg_bank_initiator: an external 4-entry bank (falling-edge write,
// combinational read) plus a reference model of register contents and
// command counts.
module tb_reg_bank_initiator;
  localparam int WIDTH = 32;
  localparam int AW    = 2;

  logic             Clock;
  logic             Reset;
  logic             CmdValid;
  logic             CmdReady;
  logic             CmdOp;
  logic [AW-1:0]    CmdReg;
  logic [AW-1:0]    CmdSrc1;
  logic [AW-1:0]    CmdSrc2;
  logic [WIDTH-1:0] CmdDado;
  logic             RespValid;
  logic             RespReady;
  logic [WIDTH-1:0] RespDado1;
  logic [WIDTH-1:0] RespDado2;
  logic [AW-1:0]    IdReg;
  logic [AW-1:0]    Fonte1;
  logic [AW-1:0]    Fonte2;
  logic             Escrita;
  logic [WIDTH-1:0] Dado;
  logic [WIDTH-1:0] DadoLido1;
  logic [WIDTH-1:0] DadoLido2;
  logic [7:0]       WrCount;
  logic [7:0]       RdCount;

  reg_bank_initiator #(.WIDTH(WIDTH), .AW(AW)) dut (
    .Clock(Clock), .Reset(Reset),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp),
    .CmdReg(CmdReg), .CmdSrc1(CmdSrc1), .CmdSrc2(CmdSrc2), .CmdDado(CmdDado),
    .RespValid(RespValid), .RespReady(RespReady),
    .RespDado1(RespDado1), .RespDado2(RespDado2),
    .IdReg(IdReg), .Fonte1(Fonte1), .Fonte2(Fonte2),
    .Escrita(Escrita), .Dado(Dado),
    .DadoLido1(DadoLido1), .DadoLido2(DadoLido2),
    .WrCount(WrCount), .RdCount(RdCount)
  );

  // External register bank
  logic [WIDTH-1:0] bank [4];
  always @(negedge Clock) if (Escrita) bank[IdReg] <= Dado;
  assign DadoLido1 = bank[Fonte1];
  assign DadoLido2 = bank[Fonte2];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  // Reference model: register contents and completed-command counts
  logic [WIDTH-1:0] model [4];
  int exp_wr = 0;
  int exp_rd = 0;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (CmdReady === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL wait_ready: CmdReady=%b required 1 within 12 cycles", CmdReady);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] r, input logic [WIDTH-1:0] d);
    wait_ready();
    CmdValid = 1'b1; CmdOp = 1'b0; CmdReg = r; CmdDado = d;
    CmdSrc1 = AW'($urandom); CmdSrc2 = AW'($urandom);
    tick();
    CmdValid = 1'b0; CmdDado = $urandom; CmdReg = AW'($urandom);
    tests++; if (Escrita !== 1'b1) begin fails++; $display("FAIL wr_escrita_on: got %b required 1", Escrita); end
    tests++; if (IdReg !== r) begin fails++; $display("FAIL wr_idreg: got %0d required %0d", IdReg, r); end
    tests++; if (Dado !== d) begin fails++; $display("FAIL wr_dado: got %h required %h", Dado, d); end
    tests++; if (CmdReady !== 1'b0) begin fails++; $display("FAIL wr_busy: CmdReady got %b required 0", CmdReady); end
    tick();
    model[r] = d;
    exp_wr = (exp_wr + 1) % 256;
    tests++; if (Escrita !== 1'b0) begin fails++; $display("FAIL wr_escrita_off: got %b required 0", Escrita); end
    tests++; if (CmdReady !== 1'b1) begin fails++; $display("FAIL wr_ready_back: got %b required 1", CmdReady); end
    tests++; if (WrCount !== 8'(exp_wr)) begin fails++; $display("FAIL wr_count: got %0d required %0d", WrCount, exp_wr); end
    tests++; if (IdReg !== r || Dado !== d) begin fails++; $display("FAIL wr_stable: IdReg=%0d Dado=%h required %0d %h", IdReg, Dado, r, d); end
  endtask

  task automatic do_read(input logic [AW-1:0] s1, input logic [AW-1:0] s2, input int hold);
    logic [WIDTH-1:0] e1, e2;
    wait_ready();
    CmdValid = 1'b1; CmdOp = 1'b1; CmdSrc1 = s1; CmdSrc2 = s2;
    CmdReg = AW'($urandom); CmdDado = $urandom; RespReady = 1'b0;
    tick();
    CmdValid = 1'b0; CmdSrc1 = AW'($urandom); CmdSrc2 = AW'($urandom);
    tests++; if (RespValid !== 1'b0) begin fails++; $display("FAIL rd_early_valid: got %b required 0", RespValid); end
    tests++; if (Fonte1 !== s1 || Fonte2 !== s2) begin fails++; $display("FAIL rd_fonte: got %0d %0d required %0d %0d", Fonte1, Fonte2, s1, s2); end
    tests++; if (CmdReady !== 1'b0) begin fails++; $display("FAIL rd_busy: CmdReady got %b required 0", CmdReady); end
    RespReady = 1'($urandom);   // must be ignored while in READ
    tick();
    RespReady = 1'b0;
    e1 = model[s1]; e2 = model[s2];
    exp_rd = (exp_rd + 1) % 256;
    tests++; if (RespValid !== 1'b1) begin fails++; $display("FAIL rd_valid: got %b required 1", RespValid); end
    tests++; if (RespDado1 !== e1) begin fails++; $display("FAIL rd_dado1: got %h required %h", RespDado1, e1); end
    tests++; if (RespDado2 !== e2) begin fails++; $display("FAIL rd_dado2: got %h required %h", RespDado2, e2); end
    tests++; if (RdCount !== 8'(exp_rd)) begin fails++; $display("FAIL rd_count: got %0d required %0d", RdCount, exp_rd); end
    for (int i = 0; i < hold; i++) begin
      CmdValid = 1'b1; CmdOp = 1'($urandom); CmdReg = AW'($urandom); CmdDado = $urandom;
      tick();
      tests++; if (RespValid !== 1'b1 || RespDado1 !== e1 || RespDado2 !== e2) begin
        fails++; $display("FAIL rd_hold: valid=%b d1=%h d2=%h required 1 %h %h", RespValid, RespDado1, RespDado2, e1, e2);
      end
      tests++; if (CmdReady !== 1'b0 || Escrita !== 1'b0 || WrCount !== 8'(exp_wr)) begin
        fails++; $display("FAIL rd_hold_ignore: ready=%b escrita=%b wr=%0d required 0 0 %0d", CmdReady, Escrita, WrCount, exp_wr);
      end
    end
    CmdValid = 1'b0;
    RespReady = 1'b1;
    tick();
    RespReady = 1'b0;
    tests++; if (RespValid !== 1'b0) begin fails++; $display("FAIL rd_release: RespValid got %b required 0", RespValid); end
    tests++; if (CmdReady !== 1'b1) begin fails++; $display("FAIL rd_idle: CmdReady got %b required 1", CmdReady); end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (Escrita !== 1'b0 || RespValid !== 1'b0 || IdReg !== '0 || Fonte1 !== '0 ||
        Fonte2 !== '0 || Dado !== '0 || RespDado1 !== '0 || RespDado2 !== '0 ||
        WrCount !== 8'd0 || RdCount !== 8'd0 || CmdReady !== 1'b1) begin
      fails++;
      $display("FAIL %s: esc=%b rv=%b id=%0d f1=%0d f2=%0d dado=%h rd1=%h rd2=%h wr=%0d rd=%0d rdy=%b required all 0 and rdy=1",
               tag, Escrita, RespValid, IdReg, Fonte1, Fonte2, Dado, RespDado1, RespDado2, WrCount, RdCount, CmdReady);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; CmdValid = 1'b0; CmdOp = 1'b0; CmdReg = '0; CmdSrc1 = '0;
    CmdSrc2 = '0; CmdDado = '0; RespReady = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset_state");
    @(negedge Clock); Reset = 1'b1;
    tick();
    check_reset_outputs("after_release");
  endtask

  task automatic test_write();
    do_write(2'd0, 32'h0000_07E3);
    do_write(2'd1, 32'hDEAD_BEEF);
    do_write(2'd2, $urandom);
    do_write(2'd3, $urandom);
  endtask

  task automatic test_read();
    do_read(2'd0, 2'd1, 0);
    tests++; if (RespDado1 !== 32'h0000_07E3 || RespDado2 !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL read_known: got %h %h required 000007e3 deadbeef", RespDado1, RespDado2);
    end
  endtask

  task automatic test_backpressure();
    do_read(2'd1, 2'd0, 5);
  endtask

  task automatic test_back_to_back();
    do_write(2'd3, 32'h1234_5678);
    do_read(2'd3, 2'd3, 0);
    tests++; if (RespDado1 !== 32'h1234_5678 || RespDado2 !== 32'h1234_5678) begin
      fails++; $display("FAIL raw_same_reg: got %h %h required 12345678 12345678", RespDado1, RespDado2);
    end
  endtask

  task automatic test_reset_mid_write();
    wait_ready();
    CmdValid = 1'b1; CmdOp = 1'b0; CmdReg = 2'd2; CmdDado = ~model[2];
    tick();
    CmdValid = 1'b0;
    tests++; if (Escrita !== 1'b1) begin fails++; $display("FAIL mid_wr_escrita: got %b required 1", Escrita); end
    #2 Reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid_write");
    @(negedge Clock); @(negedge Clock); Reset = 1'b1;
    exp_wr = 0; exp_rd = 0;
    tick();
    // The aborted write must not have reached the bank
    do_read(2'd2, 2'd2, 0);
  endtask

  task automatic test_reset_mid_read();
    wait_ready();
    CmdValid = 1'b1; CmdOp = 1'b1; CmdSrc1 = 2'd0; CmdSrc2 = 2'd1;
    tick();
    CmdValid = 1'b0;
    #2 Reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid_read");
    @(negedge Clock); Reset = 1'b1;
    exp_wr = 0; exp_rd = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (RespValid !== 1'b0 || RdCount !== 8'd0) begin
        fails++; $display("FAIL no_resp_after_reset: valid=%b rd=%0d required 0 0", RespValid, RdCount);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) do_write(AW'($urandom), $urandom);
    tests++; if (WrCount !== 8'd0) begin fails++; $display("FAIL wr_wrap: got %0d required 0", WrCount); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(1, 0) == 0) do_write(AW'($urandom), $urandom);
      else do_read(AW'($urandom), AW'($urandom), int'($urandom_range(3, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_write();
    test_reset_mid_read();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
